// File: rtl/serial_subtractor_ctrl_pkg.sv
// rtl/serial_subtractor_ctrl_pkg.sv - shared FSM encodings and default width for the serial subtractor
package serial_subtractor_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - full subtract cell from two half subtractors and an OR of their borrows
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   half_subtractor u_hs_ab (
      .a    (a),
      .b    (b),
      .d    (d1),
      .bout (b1)
   );

   half_subtractor u_hs_bin (
      .a    (d1),
      .b    (bin),
      .d    (d),
      .bout (b2)
   );

   assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - single-bit half subtractor: a - b with borrow
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial unsigned subtractor, LSB first, start/done handshake
module serial_subtractor_ctrl
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrow_out,
   output logic             zero
);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   r_sh;
   logic [WIDTH-1:0]   r_next;
   logic [CNT_W-1:0]   bit_cnt;
   logic               borrow_q;
   logic               d_bit;
   logic               borrow_next;
   logic               accept;
   logic               last_bit;

   full_subtractor u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow_q),
      .d    (d_bit),
      .bout (borrow_next)
   );

   assign accept   = (state == IDLE) && start;
   assign last_bit = (state == RUN) && (bit_cnt == CNT_W'(WIDTH - 1));
   // Bits arrive LSB first, so each new bit enters at the MSB and drifts down.
   assign r_next   = {d_bit, r_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         r_sh       <= '0;
         bit_cnt    <= '0;
         borrow_q   <= 1'b0;
         difference <= '0;
         borrow_out <= 1'b0;
         zero       <= 1'b0;
      end else if (accept) begin
         a_sh     <= operand_a;
         b_sh     <= operand_b;
         r_sh     <= '0;
         bit_cnt  <= '0;
         borrow_q <= 1'b0;
      end else if (state == RUN) begin
         a_sh     <= a_sh >> 1;
         b_sh     <= b_sh >> 1;
         r_sh     <= r_next;
         borrow_q <= borrow_next;
         if (last_bit) begin
            // Counter parks at zero instead of running past WIDTH-1.
            bit_cnt    <= '0;
            difference <= r_next;
            borrow_out <= borrow_next;
            zero       <= (r_next == '0);
         end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - directed self-checking bench for serial_subtractor_ctrl
module tb_serial_subtractor_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] difference;
   logic             borrow_out;
   logic             zero;

   int compared   = 0;
   int mismatched = 0;

   serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .busy       (busy),
      .done       (done),
      .difference (difference),
      .borrow_out (borrow_out),
      .zero       (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Wait for done, bounded; returns negedges elapsed since the accept edge.
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_d, input logic exp_bo, input logic exp_z);
      int n;
      logic [WIDTH-1:0] prev;
      prev      = difference;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_run"}, busy, 1);
      check({tag, "_done_run"}, done, 0);
      check({tag, "_held_run"}, difference, prev);
      wait_done(n);
      check({tag, "_latency"}, n, WIDTH + 1);
      check({tag, "_diff"}, difference, exp_d);
      check({tag, "_borrow"}, borrow_out, exp_bo);
      check({tag, "_zero"}, zero, exp_z);
      check({tag, "_busy_done"}, busy, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_idle"}, busy, 0);
      check({tag, "_diff_hold"}, difference, exp_d);
   endtask

   initial begin
      int n;
      int pulses;
      int last;
      reset_n   = 1'b0;
      start     = 1'b0;
      operand_a = '0;
      operand_b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", difference, 0);
      check("rst_borrow", borrow_out, 0);
      check("rst_zero", zero, 0);
      reset_n = 1'b1;
      @(negedge clk);

      run_op("t200_55", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
      run_op("t5_10", 8'd5, 8'd10, 8'hFB, 1'b1, 1'b0);
      run_op("tff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
      run_op("t0_1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

      // Extra starts and operand changes during RUN and DONE must be ignored.
      operand_a = 8'd100;
      operand_b = 8'd1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      operand_a = 8'd50;
      operand_b = 8'd40;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      check("ign_done_seen", done, 1);
      check("ign_diff", difference, 8'd99);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy_after", busy, 0);
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("ign_extra_done", pulses, 0);
      check("ign_diff_hold", difference, 8'd99);

      // Reset mid-RUN aborts with no done pulse.
      operand_a = 8'd77;
      operand_b = 8'd7;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", difference, 0);
      check("abort_borrow", borrow_out, 0);
      check("abort_zero", zero, 0);
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort_no_done", pulses, 0);
      run_op("t9_3", 8'd9, 8'd3, 8'd6, 1'b0, 1'b0);

      // Start held high: back-to-back operations every WIDTH+2 cycles.
      operand_a = 8'd3;
      operand_b = 8'd1;
      start     = 1'b1;
      pulses    = 0;
      last      = -1;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (done) begin
            if (last >= 0) check("hold_period", i - last, WIDTH + 2);
            check("hold_diff", difference, 8'd2);
            last = i;
            pulses++;
         end else if (pulses > 0) begin
            check("hold_stable", difference, 8'd2);
         end
      end
      start = 1'b0;
      check("hold_pulses", pulses, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
